// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared states, accumulator sizing and output-mapping helpers for fan_ctrl_multi
package fan_ctrl_pkg;
    typedef enum logic [3:0] {IDLE, LOAD, MAC0, MAC1, MAC2, MAC3, MAC4, WRITE, DONE} state_e;

    function automatic int acc_w(input int adc_w, input int coef_w);
        return adc_w + 1 + coef_w + 3;
    endfunction

    function automatic int sat(input int v, input int lim);
        return v > lim ? lim : (v < -lim ? -lim : v);
    endfunction

    function automatic int duty_map(input int y, input int pmin);
        return y <= 0 ? 0 : (y < pmin ? pmin : y);
    endfunction
endpackage

// File: rtl/fan_ctrl_multi_pwm.sv
// fan_pwm_out: shadowed duty register pair and comparator for one fan pin
module fan_pwm_out
    import fan_ctrl_pkg::*;
#(
    parameter int PW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [PW-1:0] cnt_i,
    input  logic          wrap_i,
    input  logic          wr_i,
    input  logic [PW-1:0] duty_i,
    output logic          pwm_o
);
    logic [PW-1:0] shadow_q, shadow_d, active_q, active_d;

    // active only changes at the period boundary so a pulse is never cut short
    always_comb begin
        shadow_d = wr_i ? duty_i : shadow_q;
        active_d = wrap_i ? shadow_q : active_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign pwm_o = cnt_i < active_q;
endmodule

// File: rtl/fan_ctrl_multi.sv
// fan_ctrl_multi: CHANNELS fan PI/IIR loops sharing one multiplier, with per-fan PWM outputs
module fan_ctrl_multi
    import fan_ctrl_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int ADC_BITWIDTH  = 4,
    parameter int COEF_BITWIDTH = 8,
    parameter int FRAC_BITWIDTH = 6,
    parameter int TICK_DIV      = 200000,
    parameter int PWM_PERIOD    = 18,
    parameter int PWM_MIN       = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clk_en_i,
    input  logic [CHANNELS*ADC_BITWIDTH-1:0]      adc_value_i,
    input  logic [CHANNELS*ADC_BITWIDTH-1:0]      set_value_i,
    input  logic [CHANNELS-1:0]                   ch_enable_i,
    input  logic [COEF_BITWIDTH-1:0]              b2_i,
    input  logic [COEF_BITWIDTH-1:0]              b1_i,
    input  logic [COEF_BITWIDTH-1:0]              b0_i,
    input  logic [COEF_BITWIDTH-1:0]              a1_i,
    input  logic [COEF_BITWIDTH-1:0]              a0_i,
    output logic [CHANNELS-1:0]                   pwm_o,
    output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0]  pid_val_o,
    output logic                                  sample_done_o,
    output logic                                  busy_o,
    output logic                                  overrun_o
);
    localparam int E_W   = ADC_BITWIDTH + 1;
    localparam int ACC_W = acc_w(ADC_BITWIDTH, COEF_BITWIDTH);
    localparam int P_W   = E_W + COEF_BITWIDTH;
    localparam int CH_W  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int T_W   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PW    = $clog2(PWM_PERIOD);
    localparam int Y_MAX = 2 ** ADC_BITWIDTH - 1;

    state_e                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [T_W-1:0]           tcnt_q, tcnt_d;
    logic                     tick_q, tick_d;
    logic [PW-1:0]            pcnt_q, pcnt_d;
    logic signed [E_W-1:0]    e_q, e_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [E_W-1:0]    e1_q [CHANNELS];
    logic signed [E_W-1:0]    e1_d [CHANNELS];
    logic signed [E_W-1:0]    e2_q [CHANNELS];
    logic signed [E_W-1:0]    e2_d [CHANNELS];
    logic signed [E_W-1:0]    y1_q [CHANNELS];
    logic signed [E_W-1:0]    y1_d [CHANNELS];
    logic signed [E_W-1:0]    y2_q [CHANNELS];
    logic signed [E_W-1:0]    y2_d [CHANNELS];
    logic signed [E_W-1:0]    pid_q [CHANNELS];
    logic signed [E_W-1:0]    pid_d [CHANNELS];

    logic [ADC_BITWIDTH-1:0]          adc_sel, set_sel;
    logic signed [E_W-1:0]            e_load, opnd, y_w;
    logic signed [COEF_BITWIDTH-1:0]  coef;
    logic signed [P_W-1:0]            prod;
    logic signed [ACC_W-1:0]          prod_x, acc_sh;
    logic [PW-1:0]                    duty_w;
    logic                             pwrap, wr, en, mac, sub, last;

    always_comb begin
        tcnt_d = !clk_en_i ? tcnt_q : (tcnt_q == T_W'(TICK_DIV - 1) ? '0 : tcnt_q + 1'b1);
        tick_d = clk_en_i ? tcnt_q == T_W'(TICK_DIV - 1) : tick_q;
        pwrap  = clk_en_i && pcnt_q == PW'(PWM_PERIOD - 1);
        pcnt_d = !clk_en_i ? pcnt_q : (pwrap ? '0 : pcnt_q + 1'b1);
    end

    assign adc_sel = adc_value_i[ch_q*ADC_BITWIDTH +: ADC_BITWIDTH];
    assign set_sel = set_value_i[ch_q*ADC_BITWIDTH +: ADC_BITWIDTH];
    assign e_load  = $signed({1'b0, adc_sel}) - $signed({1'b0, set_sel});

    // one product per MAC state through the single shared multiplier
    always_comb begin
        coef = state_q == MAC0 ? b2_i : state_q == MAC1 ? b1_i : state_q == MAC2 ? b0_i :
               state_q == MAC3 ? a1_i : a0_i;
        opnd = state_q == MAC0 ? e_q : state_q == MAC1 ? e1_q[ch_q] : state_q == MAC2 ? e2_q[ch_q] :
               state_q == MAC3 ? y1_q[ch_q] : y2_q[ch_q];
    end

    assign prod   = coef * opnd;
    assign prod_x = prod;
    assign mac    = state_q inside {MAC0, MAC1, MAC2, MAC3, MAC4};
    assign sub    = state_q inside {MAC3, MAC4};
    assign acc_sh = acc_q >>> FRAC_BITWIDTH;
    assign en     = ch_enable_i[ch_q];
    assign y_w    = en ? E_W'(sat(int'(acc_sh), Y_MAX)) : '0;
    assign duty_w = PW'(duty_map(int'(y_w), PWM_MIN));
    assign wr     = clk_en_i && state_q == WRITE;
    assign last   = ch_q == CH_W'(CHANNELS - 1);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        e_d     = e_q;
        acc_d   = acc_q;
        if (clk_en_i) begin
            case (state_q)
                IDLE:  begin
                    state_d = tick_q ? LOAD : IDLE;
                    ch_d    = '0;
                end
                LOAD:  begin
                    state_d = MAC0;
                    e_d     = e_load;
                    acc_d   = '0;
                end
                MAC0:  state_d = MAC1;
                MAC1:  state_d = MAC2;
                MAC2:  state_d = MAC3;
                MAC3:  state_d = MAC4;
                MAC4:  state_d = WRITE;
                WRITE: begin
                    state_d = last ? DONE : LOAD;
                    ch_d    = last ? '0 : ch_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if (mac)
                acc_d = sub ? acc_q - prod_x : acc_q + prod_x;
        end
    end

    // a disabled channel drops its whole history so re-enabling starts clean
    always_comb begin
        e1_d  = e1_q;
        e2_d  = e2_q;
        y1_d  = y1_q;
        y2_d  = y2_q;
        pid_d = pid_q;
        if (wr) begin
            e2_d[ch_q]  = en ? e1_q[ch_q] : '0;
            e1_d[ch_q]  = en ? e_q : '0;
            y2_d[ch_q]  = en ? y1_q[ch_q] : '0;
            y1_d[ch_q]  = y_w;
            pid_d[ch_q] = y_w;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ch_q    <= '0;
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
            pcnt_q  <= '0;
            e_q     <= '0;
            acc_q   <= '0;
            e1_q    <= '{default: '0};
            e2_q    <= '{default: '0};
            y1_q    <= '{default: '0};
            y2_q    <= '{default: '0};
            pid_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_d;
            pcnt_q  <= pcnt_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            pid_q   <= pid_d;
        end
    end

    assign busy_o        = state_q != IDLE;
    assign sample_done_o = clk_en_i && state_q == DONE;
    assign overrun_o     = clk_en_i && tick_q && state_q != IDLE;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign pid_val_o[c*E_W +: E_W] = pid_q[c];
        fan_pwm_out #(.PW(PW)) u_pwm (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .cnt_i  (pcnt_q),
            .wrap_i (pwrap),
            .wr_i   (wr && ch_q == CH_W'(c)),
            .duty_i (duty_w),
            .pwm_o  (pwm_o[c])
        );
    end
endmodule

// File: tb/tb_fan_ctrl_multi.sv
// tb_fan_ctrl_multi: directed checks of fan_ctrl_multi with a pid_val scoreboard
module tb_fan_ctrl_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [7:0]  adc = '0, set = '0;
    logic [1:0]  ch_en = 2'b11;
    logic [7:0]  b2 = 8'd94, b1 = 8'(-93), b0 = 8'd0, a1 = 8'(-64), a0 = 8'd0;
    logic [1:0]  pwm;
    logic [9:0]  pid;
    logic        done, busy, ovr;
    int          passed = 0, total = 0;
    logic [9:0]  exp_q[$];

    fan_ctrl_multi #(
        .CHANNELS(2), .ADC_BITWIDTH(4), .COEF_BITWIDTH(8), .FRAC_BITWIDTH(6),
        .TICK_DIV(10), .PWM_PERIOD(18), .PWM_MIN(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
        .adc_value_i(adc), .set_value_i(set), .ch_enable_i(ch_en),
        .b2_i(b2), .b1_i(b1), .b0_i(b0), .a1_i(a1), .a0_i(a0),
        .pwm_o(pwm), .pid_val_o(pid), .sample_done_o(done), .busy_o(busy), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [9:0] pk(input int y0, input int y1);
        return {5'(y1), 5'(y0)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        if (!done) chk("done_seen", done, 1);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 100 && !busy; i++) @(negedge clk);
        if (!busy) chk("busy_seen", busy, 1);
    endtask

    task automatic step(input string tag, input logic [9:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        wait_done();
        chk(tag, pid, exp_q.pop_front());
    endtask

    task automatic count_hi(input int c, output int n);
        n = 0;
        repeat (18) begin
            @(negedge clk);
            n += int'(pwm[c]);
        end
    endtask

    initial begin
        int n, len, done_off, ovr_off, nd, no;
        repeat (3) @(negedge clk);
        chk("reset_pwm", 32'(pwm), 0);
        chk("reset_pid", 32'(pid), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        adc = 8'h44;
        @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_ovr", 32'(ovr), 0);

        // sweep timing and overrun cadence
        wait_busy();
        len = 0; done_off = -1; ovr_off = -1;
        while (busy && len < 100) begin
            if (done) done_off = len;
            if (ovr) ovr_off = len;
            len++;
            @(negedge clk);
        end
        chk("busy_len", 32'(len), 15);
        chk("done_offset", 32'(done_off), 14);
        chk("overrun_offset", 32'(ovr_off), 9);
        nd = 0; no = 0;
        repeat (200) begin
            nd += int'(done);
            no += int'(ovr);
            @(negedge clk);
        end
        chk("sweeps_in_200", 32'(nd), 10);
        chk("overruns_in_200", 32'(no), 10);

        // steady error
        do_reset();
        step("steady_s0", pk(5, 5));
        step("steady_s1", pk(5, 5));
        count_hi(0, n); chk("steady_pwm0", 32'(n), 5);
        count_hi(1, n); chk("steady_pwm1", 32'(n), 5);

        // clk_en low freezes the sweep
        wait_busy();
        @(negedge clk);
        clk_en = 1'b0;
        nd = 0; no = 0;
        repeat (40) begin
            @(negedge clk);
            nd += int'(done);
            no += int'(ovr);
        end
        chk("hold_pulses", 32'(nd + no), 0);
        chk("hold_busy", 32'(busy), 1);
        chk("hold_pid", 32'(pid), 32'(pk(5, 5)));
        clk_en = 1'b1;
        step("hold_resume", pk(5, 5));

        // saturation both ways
        do_reset();
        adc = 8'h0F; set = 8'hF0;
        step("sat_s0", pk(15, -15));
        step("sat_s1", pk(15, -15));
        count_hi(0, n); chk("sat_pwm0", 32'(n), 15);
        count_hi(1, n); chk("sat_pwm1", 32'(n), 0);

        // reset mid-sweep clears history and restarts at channel 0
        adc = 8'h44; set = 8'h00;
        wait_busy();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pid", 32'(pid), 0);
        chk("midrst_pwm", 32'(pwm), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step("midrst_first", pk(5, 5));

        // minimum duty
        do_reset();
        ch_en = 2'b01; adc = 8'h01;
        step("min_s0", pk(1, 0));
        step("min_s1", pk(1, 0));
        count_hi(0, n); chk("min_pwm0", 32'(n), 3);

        // per-channel enable
        do_reset();
        ch_en = 2'b11; adc = 8'hF4;
        step("en_both", pk(5, 15));
        ch_en = 2'b01;
        step("en_ch1_off", pk(5, 0));
        ch_en = 2'b11; adc = 8'h44;
        step("en_ch1_back", pk(5, 5));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fan_ctrl_multi.md
# fan_ctrl_multi

Multi-channel successor to the single-fan PI controller. It runs CHANNELS independent temperature loops on one time-multiplexed IIR/PI datapath with a single shared multiplier, and drives one PWM output per fan. It sits between the per-channel ADC/setpoint inputs and the fan pins. It adds a programmable sample rate, per-channel enable, output saturation, glitch-free duty update and overrun reporting.

## Interface
- CHANNELS, 2: number of fan loops (1..8)
- ADC_BITWIDTH, 4: ADC and setpoint width per channel
- COEF_BITWIDTH, 8: signed coefficient width
- FRAC_BITWIDTH, 6: fractional bits of the coefficients
- TICK_DIV, 200000: clk_en cycles per sample (5 Hz at 1 MHz)
- PWM_PERIOD, 18: PWM period in clk_en cycles; must be > 2^ADC_BITWIDTH-1
- PWM_MIN, 3: minimum duty when the fan is on
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clk_en_i  in  1  advances all counters and the FSM
- adc_value_i  in  CHANNELS*ADC_BITWIDTH  measured value, channel c at [c*ADC_BITWIDTH +: ADC_BITWIDTH]
- set_value_i  in  CHANNELS*ADC_BITWIDTH  setpoint, same packing
- ch_enable_i  in  CHANNELS  loop enable per channel
- b2_i, b1_i, b0_i, a1_i, a0_i  in  COEF_BITWIDTH each  signed coefficients, shared by all channels
- pwm_o  out  CHANNELS  fan PWM pins
- pid_val_o  out  CHANNELS*(ADC_BITWIDTH+1)  signed controller output per channel
- sample_done_o  out  1  one-cycle pulse after the last channel is written
- busy_o  out  1  high while the FSM is not IDLE
- overrun_o  out  1  one-cycle pulse when a tick arrives while busy

## Operation
- Reset: all outputs 0; history registers (e1, e2, y1, y2) zero; tick counter, PWM counter and duty registers 0; FSM in IDLE.
- Tick counter counts clk_en_i cycles from 0 to TICK_DIV-1, then wraps. Wrap raises tick.
- A tick in IDLE starts a sweep. A tick while busy is dropped and pulses overrun_o.
- Sweep: channels 0..CHANNELS-1 in order. Each channel passes through the states LOAD, MAC0..MAC4, WRITE. After the last channel the FSM enters DONE, then returns to IDLE. The FSM advances only on clk_en_i.
- LOAD: e = adc - set, sign-extended to ADC_BITWIDTH+1 bits. Positive e means too hot.
- MAC: acc = b2·e + b1·e1 + b0·e2 − a1·y1 − a0·y2, one product per state. ACC_W = ADC_BITWIDTH+1+COEF_BITWIDTH+3, signed.
- WRITE:
  - y = acc >>> FRAC_BITWIDTH (arithmetic shift, floor), saturated to ±(2^ADC_BITWIDTH − 1).
  - Shift the channel's history: e2←e1, e1←e, y2←y1, y1←y.
  - Drive y onto the channel's pid_val_o slice.
- Disabled channel: takes the same number of cycles. WRITE forces y=0 and clears all four history registers.
- Duty calculation: y ≤ 0 gives duty 0. y > 0 gives duty = max(y, PWM_MIN).
- Duty shadowing: duty is staged, then copied to the active register only when the PWM counter wraps to 0.
- PWM: a shared counter runs 0..PWM_PERIOD-1 on clk_en_i. pwm_o[c] = (counter < active_duty[c]).

## Timing
- Tick registered at edge T → LOAD of channel 0 at T+1.
- 7 enabled cycles per channel. pid_val_o[c] is valid after the WRITE edge at T+7(c+1).
- DONE at T+7·CHANNELS+1; sample_done_o is high during that cycle. busy_o is high from T+1 through DONE.
- A new duty appears on pwm_o within one PWM period after the WRITE.
- With clk_en_i low, everything holds and no pulses are generated.
- rst_i mid-sweep aborts immediately: all registers are cleared and there is no partial write.

## Structure
- Package fan_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, MAC0..MAC4, WRITE, DONE);
  - an ACC_W function;
  - a saturate function;
  - a duty-mapping function.
- Sub-module fan_pwm_out, one instance per channel: shadow and active duty registers plus the comparator. It is fed by the shared counter and its wrap strobe.
- The top holds the tick counter, FSM, shared MAC and history register file.

## Test plan
- Reset: assert rst_i mid-sweep → all outputs 0 and busy_o low at once; next tick restarts at channel 0.
- Steady error: b2=94, b1=-93, b0=0, a1=-64, a0=0, adc=4, set=0 → pid_val=5 at sample 0 and sample 1; pwm_o high 5 of 18 cycles.
- Saturation: adc=15, set=0 → acc=1410, y=+15, then y stays 15. With adc=0, set=15 → y=−15, pwm_o constantly 0.
- Min duty: coefficients give y=1 (adc=1, set=0) → pwm_o high 3 of 18 cycles.
- Channel independence and enable: ch0 adc=4, ch1 disabled → ch1 pid_val=0 and its history is cleared. Re-enabling ch1 with adc=4 gives 5 on its first sample.
- Overrun and timing: TICK_DIV=10, CHANNELS=2 → busy_o lasts 15 cycles, so every tick lands while busy, pulses overrun_o and is dropped. Result: one sweep per two ticks. Check sample_done_o lands at T+15.
